// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, selects and forwards operands, handles stall/flush.
// Optional macro ID_EX_FORWARD_EN enables writeback forwarding at capture and while holding.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic [5:0]      alu_ctrl,
  output logic            branch_op,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [4:0]      rd_out,
  output logic            reg_write,
  output logic [XLEN-1:0] pc_out,
  output logic            out_valid,
  output logic            illegal
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [5:0] CTRL_PASS = 6'b111111;

  // a_rs/b_rs and the stored indices let a held operand pick up a late writeback.
  typedef struct packed {
    logic            valid;
    logic [5:0]      alu_ctrl;
    logic            branch_op;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic            a_rs;
    logic            b_rs;
    logic [4:0]      a_idx;
    logic [4:0]      b_idx;
    logic            illegal;
  } stage_t;

  stage_t stage_d, stage_q;

  function automatic logic fwd_hit(input logic we, input logic [4:0] wr_idx,
                                   input logic [4:0] idx);
    return FWD_EN && we && (idx != 5'd0) && (idx == wr_idx);
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [5:0]      dec_ctrl;
  logic            dec_legal, dec_branch, dec_rw;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_a_rs, dec_b_rs;

  assign rs1_val = fwd_hit(fwd_we, fwd_rd, rs1) ? fwd_data : rs1_data;
  assign rs2_val = fwd_hit(fwd_we, fwd_rd, rs2) ? fwd_data : rs2_data;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    dec_legal  = 1'b1;
    dec_ctrl   = 6'b000000;
    dec_branch = 1'b0;
    dec_rw     = 1'b1;
    dec_a      = rs1_val;
    dec_a_rs   = 1'b1;
    dec_b      = rs2_val;
    dec_b_rs   = 1'b1;
    case (opcode)
      OP_R: dec_ctrl = {2'b00, funct7[5], funct3};
      OP_I: begin
        // Only SRAI carries funct7[5]; ADDI with a stray bit must not become SUB.
        dec_ctrl = {2'b00, (funct3 == 3'b101) & funct7[5], funct3};
        dec_b    = imm;
        dec_b_rs = 1'b0;
      end
      OP_LOAD: begin
        dec_b    = imm;
        dec_b_rs = 1'b0;
      end
      OP_STORE: begin
        dec_b    = imm;
        dec_b_rs = 1'b0;
        dec_rw   = 1'b0;
      end
      OP_BRANCH: begin
        dec_ctrl   = {3'b010, funct3};
        dec_branch = 1'b1;
        dec_rw     = 1'b0;
        dec_legal  = (funct3[2:1] != 2'b01);
      end
      OP_LUI: begin
        dec_ctrl = CTRL_PASS;
        dec_a    = '0;
        dec_a_rs = 1'b0;
        dec_b    = imm;
        dec_b_rs = 1'b0;
      end
      OP_AUIPC: begin
        dec_a    = pc;
        dec_a_rs = 1'b0;
        dec_b    = imm;
        dec_b_rs = 1'b0;
      end
      OP_JAL, OP_JALR: begin
        dec_ctrl = CTRL_PASS;
        dec_b    = pc + XLEN'(4);
        dec_b_rs = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    stage_d         = stage_q;
    stage_d.illegal = 1'b0;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      if (stage_q.a_rs && fwd_hit(fwd_we, fwd_rd, stage_q.a_idx)) stage_d.a = fwd_data;
      if (stage_q.b_rs && fwd_hit(fwd_we, fwd_rd, stage_q.b_idx)) stage_d.b = fwd_data;
    end else if (!in_valid || !dec_legal) begin
      stage_d         = '0;
      stage_d.illegal = in_valid;
    end else begin
      stage_d.valid     = 1'b1;
      stage_d.alu_ctrl  = dec_ctrl;
      stage_d.branch_op = dec_branch;
      stage_d.reg_write = dec_rw;
      stage_d.rd        = rd;
      stage_d.a         = dec_a;
      stage_d.b         = dec_b;
      stage_d.pc        = pc;
      stage_d.a_rs      = dec_a_rs;
      stage_d.b_rs      = dec_b_rs;
      stage_d.a_idx     = rs1;
      stage_d.b_idx     = rs2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign alu_ctrl  = stage_q.alu_ctrl;
  assign branch_op = stage_q.branch_op;
  assign operand_a = stage_q.a;
  assign operand_b = stage_q.b;
  assign rd_out    = stage_q.rd;
  assign reg_write = stage_q.reg_write;
  assign pc_out    = stage_q.pc;
  assign out_valid = stage_q.valid;
  assign illegal   = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN when defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [6:0]      opcode = '0, funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [4:0]      rs1 = '0, rs2 = '0, rd = '0, fwd_rd = '0;
  logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0, fwd_data = '0;
  logic            fwd_we = 1'b0;
  logic [5:0]      alu_ctrl;
  logic            branch_op, reg_write, out_valid, illegal;
  logic [XLEN-1:0] operand_a, operand_b, pc_out;
  logic [4:0]      rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .alu_ctrl(alu_ctrl), .branch_op(branch_op), .operand_a(operand_a), .operand_b(operand_b),
    .rd_out(rd_out), .reg_write(reg_write), .pc_out(pc_out), .out_valid(out_valid),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] im, input logic [31:0] p);
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = d; rs1_data = d1; rs2_data = d2; imm = im; pc = p;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] hold_a, hold_b;
    // Reset asserted asynchronously before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_pc", pc_out, 0);
    check("rst_illegal", illegal, 0);
    drive(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd5, 32'd4, 32'd5, 32'd0, 32'h40);
    @(negedge clock) reset = 1'b1;
    step();
    check("add_ctrl", alu_ctrl, 6'b000000);
    check("add_a", operand_a, 4);
    check("add_b", operand_b, 5);
    check("add_valid", out_valid, 1);
    check("add_rd", rd_out, 5);
    check("add_pc", pc_out, 32'h40);

    // Reset between edges clears outputs immediately.
    #3 reset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_a", operand_a, 0);
    check("midrst_rw", reg_write, 0);
    @(negedge clock) reset = 1'b1;
    step();
    check("postrst_valid", out_valid, 1);
    check("postrst_a", operand_a, 4);
    check("postrst_b", operand_b, 5);

    drive(7'b0010011, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd7, 32'h44);
    step();
    check("addi_ctrl", alu_ctrl, 6'b000000);
    check("addi_b", operand_b, 7);
    drive(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd3, 32'h48);
    step();
    check("srai_ctrl", alu_ctrl, 6'b001101);
    drive(7'b0110011, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd0, 32'h4c);
    step();
    check("sub_ctrl", alu_ctrl, 6'b001000);
    drive(7'b0110011, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd0, 32'h50);
    step();
    check("slt_ctrl", alu_ctrl, 6'b000010);

    drive(7'b1100011, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd8, 32'h54);
    step();
    check("bgeu_ctrl", alu_ctrl, 6'b010111);
    check("bgeu_br", branch_op, 1);
    check("bgeu_rw", reg_write, 0);
    drive(7'b1100011, 3'b100, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd8, 32'h58);
    step();
    check("blt_ctrl", alu_ctrl, 6'b010100);
    drive(7'b1101111, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd16, 32'h100);
    step();
    check("jal_ctrl", alu_ctrl, 6'b111111);
    check("jal_b", operand_b, 32'h104);
    check("jal_rw", reg_write, 1);
    check("jal_br", branch_op, 0);
    drive(7'b1100011, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 32'd8, 32'h104);
    step();
    check("badbr_illegal", illegal, 1);
    check("badbr_valid", out_valid, 0);
    check("badbr_ctrl", alu_ctrl, 0);
    drive(7'b0110111, 3'b000, 7'b0000000, 5'd7, 5'd2, 5'd9, 32'd4, 32'd5, 32'h12345000, 32'h108);
    step();
    check("illegal_pulse", illegal, 0);
    check("lui_a", operand_a, 0);
    check("lui_b", operand_b, 32'h12345000);
    check("lui_ctrl", alu_ctrl, 6'b111111);
    drive(7'b0010111, 3'b000, 7'b0000000, 5'd7, 5'd2, 5'd9, 32'd4, 32'd5, 32'h1000, 32'h10c);
    step();
    check("auipc_a", operand_a, 32'h10c);
    drive(7'b0100011, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd0, 32'd4, 32'd5, 32'd12, 32'h110);
    step();
    check("store_rw", reg_write, 0);
    check("store_b", operand_b, 12);

    // Forwarding at capture; x0 never forwards.
    drive(7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 32'h114);
    fwd_we = 1'b1; fwd_rd = 5'd3; fwd_data = 32'h20;
    step();
    check("fwd_a", operand_a, FWD ? 32'h20 : 32'h1);
    check("fwd_b", operand_b, 2);
    rs1 = 5'd0; fwd_rd = 5'd0;
    step();
    check("fwd_x0_a", operand_a, 1);
    fwd_we = 1'b0;

    // Stall holds, then a writeback to the held rs2 updates b.
    drive(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd6, 5'd8, 32'hA, 32'hB, 32'd0, 32'h118);
    step();
    hold_a = operand_a; hold_b = operand_b;
    stall = 1'b1;
    drive(7'b0010011, 3'b111, 7'b0000000, 5'd9, 5'd9, 5'd9, 32'h55, 32'h66, 32'h77, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_a", operand_a, 32'hA);
      check("stall_b", operand_b, 32'hB);
      check("stall_rd", rd_out, 8);
      check("stall_valid", out_valid, 1);
    end
    fwd_we = 1'b1; fwd_rd = 5'd6; fwd_data = 32'hF;
    step();
    check("stall_fwd_b", operand_b, FWD ? 32'hF : 32'hB);
    check("stall_fwd_a", operand_a, hold_a);
    fwd_we = 1'b0;
    flush = 1'b1;
    step();
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", alu_ctrl, 0);
    check("flush_b", operand_b, 0);
    flush = 1'b0; stall = 1'b0;

    drive(7'b1111111, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5, 32'd0, 32'h300);
    step();
    check("badop_illegal", illegal, 1);
    stall = 1'b1;
    step();
    check("stalled_badop_illegal", illegal, 0);
    stall = 1'b0; in_valid = 1'b0;
    step();
    check("invalid_valid", out_valid, 0);
    check("invalid_illegal", illegal, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
